// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline constants for the hazard/stall controller: default
// multiply/divide latencies, Tuse/Tnew encoding and busy-counter states.
package stall_ctrl_pkg;

    // Default busy latencies of the multiply/divide unit, in cycles.
    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    // Tuse/Tnew fields are small cycle counts.
    localparam int TW = 2;
    typedef logic [TW-1:0] tick_t;

    // Tuse value meaning "this operand is never read".
    localparam tick_t TUSE_NONE = 2'd3;

    // Busy-counter states, derived from whether the count is zero.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Larger of two latencies, used to size the busy counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide busy counter: loads the operation latency when a start is
// seen while idle, then counts down to zero. Starts while busy are ignored.
module md_busy_cnt
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_CYC = max_int(MULT_CYCLES, DIV_CYCLES);
    localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [0:0]    state;

    assign state = (count_reg != '0) ? ST_BUSY : ST_IDLE;

    // Next count: load on an idle start, count down while busy (never below 0).
    always_comb begin
        count_next = count_reg;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    count_next = is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            ST_BUSY: begin
                count_next = count_reg - 1'b1;
            end
            default: begin
                count_next = '0;
            end
        endcase
    end

    // Count register; reset aborts any operation and wins over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign busy = (state == ST_BUSY);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: detects RAW hazards of the instruction in D
// against E and M using Tuse/Tnew, plus multiply/divide unit conflicts,
// and freezes F/D while inserting a bubble into D/E.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    D_rs,
    input  logic [4:0]    D_rt,
    input  logic [TW-1:0] D_Tuse_rs,
    input  logic [TW-1:0] D_Tuse_rt,
    input  logic          D_is_md,
    input  logic [4:0]    E_A3,
    input  logic [TW-1:0] E_Tnew,
    input  logic [4:0]    M_A3,
    input  logic [TW-1:0] M_Tnew,
    input  logic          E_md_start,
    input  logic          E_md_div,
    output logic          F_PC_en,
    output logic          D_Reg_en,
    output logic          E_Reg_clr,
    output logic          md_busy
);

    logic [4:0] src  [2];
    tick_t      tuse [2];
    logic [1:0] opnd_stall;
    logic       rs_stall;
    logic       rt_stall;
    logic       md_stall;
    logic       stall;

    assign src[0]  = D_rs;
    assign src[1]  = D_rt;
    assign tuse[0] = D_Tuse_rs;
    assign tuse[1] = D_Tuse_rt;

    // Per-operand hazard: register 0 never conflicts, and an operand is
    // stalled only when a producer in E or M delivers later than it is needed.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            logic used;
            logic hit_e;
            logic hit_m;
            assign used  = (tuse[gi] != TUSE_NONE);
            assign hit_e = (src[gi] == E_A3) && (E_Tnew > tuse[gi]);
            assign hit_m = (src[gi] == M_A3) && (M_Tnew > tuse[gi]);
            assign opnd_stall[gi] = used && (src[gi] != 5'd0) && (hit_e || hit_m);
        end
    endgenerate

    assign rs_stall = opnd_stall[0];
    assign rt_stall = opnd_stall[1];

    // A md instruction waits while the unit is busy or just being started.
    assign md_stall = D_is_md && (md_busy || E_md_start);

    assign stall     = rs_stall || rt_stall || md_stall;
    assign F_PC_en   = ~stall;
    assign D_Reg_en  = ~stall;
    assign E_Reg_clr = stall;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (E_md_start),
        .is_div (E_md_div),
        .busy   (md_busy)
    );

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: each vector drives one cycle of inputs and
// queues the hand-computed outputs; a negedge monitor pops and compares.
module tb_stall_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_A3, M_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic       D_is_md, E_md_start, E_md_div;
    logic       F_PC_en, D_Reg_en, E_Reg_clr, md_busy;

    typedef struct {
        string name;
        logic  stall;
        logic  busy;
    } exp_t;

    exp_t exp_q[$];
    logic vec_valid;
    int   n_checks;
    int   n_pass;

    stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_Tuse_rs  (D_Tuse_rs),
        .D_Tuse_rt  (D_Tuse_rt),
        .D_is_md    (D_is_md),
        .E_A3       (E_A3),
        .E_Tnew     (E_Tnew),
        .M_A3       (M_A3),
        .M_Tnew     (M_Tnew),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .F_PC_en    (F_PC_en),
        .D_Reg_en   (D_Reg_en),
        .E_Reg_clr  (E_Reg_clr),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue its expected outputs.
    task automatic vec(input string name, input logic rst,
                       input int rs, input int trs, input int rt, input int trt,
                       input logic is_md, input int ea3, input int etn,
                       input int ma3, input int mtn, input logic st, input logic dv,
                       input logic e_stall, input logic e_busy);
        exp_t e;
        reset      = rst;
        D_rs       = 5'(rs);
        D_Tuse_rs  = 2'(trs);
        D_rt       = 5'(rt);
        D_Tuse_rt  = 2'(trt);
        D_is_md    = is_md;
        E_A3       = 5'(ea3);
        E_Tnew     = 2'(etn);
        M_A3       = 5'(ma3);
        M_Tnew     = 2'(mtn);
        E_md_start = st;
        E_md_div   = dv;
        e.name  = name;
        e.stall = e_stall;
        e.busy  = e_busy;
        exp_q.push_back(e);
        vec_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Idle cycle with optional md_is flag, start and reset.
    task automatic idle(input string name, input logic rst, input logic is_md,
                        input logic st, input logic dv,
                        input logic e_stall, input logic e_busy);
        vec(name, rst, 0, 3, 0, 3, is_md, 0, 0, 0, 0, st, dv, e_stall, e_busy);
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (vec_valid && exp_q.size() > 0) begin
            exp_t e;
            logic ok;
            e = exp_q.pop_front();
            ok = (F_PC_en === ~e.stall) && (D_Reg_en === ~e.stall) &&
                 (E_Reg_clr === e.stall) && (md_busy === e.busy);
            n_checks++;
            if (ok) begin
                n_pass++;
                $display("ok   %s: pc_en=%b d_en=%b e_clr=%b md_busy=%b", e.name,
                         F_PC_en, D_Reg_en, E_Reg_clr, md_busy);
            end else begin
                $display("FAIL %s: got pc_en=%b d_en=%b e_clr=%b md_busy=%b, want pc_en=%b d_en=%b e_clr=%b md_busy=%b",
                         e.name, F_PC_en, D_Reg_en, E_Reg_clr, md_busy,
                         ~e.stall, ~e.stall, e.stall, e.busy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        vec_valid  = 1'b0;
        reset      = 1'b1;
        D_rs = 0; D_rt = 0; D_Tuse_rs = 3; D_Tuse_rt = 3; D_is_md = 0;
        E_A3 = 0; E_Tnew = 0; M_A3 = 0; M_Tnew = 0;
        E_md_start = 0; E_md_div = 0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state and register hazards.
        idle("reset_idle", 1, 0, 0, 0, 0, 0);
        vec("rs_e_hazard",   0, 5, 0, 0, 3, 0, 5, 1, 0, 0, 0, 0, 1, 0);
        vec("rs_zero",       0, 0, 0, 0, 3, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        vec("rt_m_hazard",   0, 0, 3, 7, 1, 0, 0, 0, 7, 2, 0, 0, 1, 0);
        vec("rt_m_equal",    0, 0, 3, 7, 1, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        vec("rs_tuse_none",  0, 9, 3, 0, 3, 0, 9, 2, 0, 0, 0, 0, 0, 0);
        vec("rs_other_reg",  0, 4, 0, 0, 3, 0, 5, 2, 0, 0, 0, 0, 0, 0);
        vec("rs_rt_both",    0, 3, 0, 6, 0, 0, 3, 1, 6, 1, 0, 0, 1, 0);
        vec("rt_zero_m",     0, 0, 3, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);

        // Mult start, no md instruction in D: busy exactly 5 cycles, no stall.
        idle("mult_start", 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) idle($sformatf("mult_busy%0d", i), 0, 0, 0, 0, 0, 1);
        idle("mult_done", 0, 0, 0, 0, 0, 0);

        // Div start with md instruction held in D: 11 stall cycles.
        idle("div_start_md", 0, 1, 1, 1, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 3)
                vec("div_busy3_plus_rs", 0, 5, 0, 0, 3, 1, 5, 1, 0, 0, 0, 0, 1, 1);
            else
                idle($sformatf("div_busy%0d_md", i), 0, 1, 0, 0, 1, 1);
        end
        idle("div_release_md", 0, 1, 0, 0, 0, 0);

        // Div aborted by reset at busy cycle 4; start during reset ignored.
        idle("div2_start", 0, 0, 1, 1, 0, 0);
        for (int i = 1; i <= 3; i++) idle($sformatf("div2_busy%0d", i), 0, 0, 0, 0, 0, 1);
        idle("div2_busy4_reset", 1, 0, 1, 1, 0, 1);
        idle("after_reset", 0, 0, 0, 0, 0, 0);
        idle("reset_with_start", 1, 1, 1, 0, 1, 0);
        idle("start_in_reset_ignored", 0, 0, 0, 0, 0, 0);
        idle("still_idle", 0, 0, 0, 0, 0, 0);

        // Second start during a mult does not extend it.
        idle("mult2_start", 0, 0, 1, 0, 0, 0);
        idle("mult2_busy1", 0, 0, 0, 0, 0, 1);
        idle("mult2_busy2_restart", 0, 0, 1, 1, 0, 1);
        for (int i = 3; i <= 5; i++) idle($sformatf("mult2_busy%0d", i), 0, 0, 0, 0, 0, 1);
        idle("mult2_done", 0, 0, 0, 0, 0, 0);

        vec_valid = 1'b0;
        @(posedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
